// File: rtl/cordic_seq_pkg.sv
// cordic_seq_pkg: shared encodings and the repeat-index recurrence for the CORDIC sequencer.
package cordic_seq_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    localparam logic MODE_CIRC = 1'b0;
    localparam logic MODE_HYP = 1'b1;
    localparam int FIRST_REP = 4;

    function automatic int unsigned next_rep_f(input int unsigned k);
        return 3 * k + 1;
    endfunction
endpackage

// File: rtl/cordic_rep_point.sv
// cordic_rep_point: tracks the next hyperbolic repeat index and whether the current step is its second pass.
module cordic_rep_point
    import cordic_seq_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             init_i,
    input  logic             adv_i,
    input  logic             hyp_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             hit_o,
    output logic             rep_o
);
    // Two spare bits keep 3k+1 from wrapping back into the index range.
    localparam int NR_W = IDX_W + 2;

    logic [NR_W-1:0] nr_q, nr_d;
    logic            rep_q, rep_d;

    always_comb begin
        hit_o = ({2'b00, idx_i} == nr_q) && !rep_q;
        rep_d = init_i ? 1'b0 : (adv_i && hyp_i) ? hit_o : rep_q;
        nr_d = init_i ? NR_W'(FIRST_REP)
             : (adv_i && hyp_i && rep_q) ? NR_W'(next_rep_f(32'(nr_q))) : nr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            nr_q <= NR_W'(FIRST_REP);
            rep_q <= 1'b0;
        end else begin
            nr_q <= nr_d;
            rep_q <= rep_d;
        end
    end

    assign rep_o = rep_q;
endmodule

// File: rtl/cordic_iter_seq.sv
// cordic_iter_seq: issues CORDIC shift indices with start/busy/done handshake and adv-driven stepping.
module cordic_iter_seq
    import cordic_seq_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int MAX_IDX = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             adv_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             step_valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic             rep_o,
    output logic [CNT_W-1:0] step_cnt_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [IDX_W-1:0] MAX_L = IDX_W'(MAX_IDX);

    logic [0:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             accept, step, hit, hyp_hit, last;

    cordic_rep_point #(.IDX_W(IDX_W)) u_rep (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .init_i  (accept),
        .adv_i   (step && !last),
        .hyp_i   (mode_q == MODE_HYP),
        .idx_i   (idx_q),
        .hit_o   (hit),
        .rep_o   (rep_o)
    );

    always_comb begin
        accept = (state_q == ST_IDLE) && start_i;
        step = (state_q == ST_RUN) && adv_i;
        hyp_hit = (mode_q == MODE_HYP) && hit;
        last = (state_q == ST_RUN) && (idx_q == MAX_L) && !hyp_hit;
        state_d = accept ? ST_RUN : (step && last) ? ST_IDLE : state_q;
        mode_d = accept ? mode_i : mode_q;
        idx_d = accept ? IDX_W'(mode_i == MODE_HYP) : (step && !last && !hyp_hit) ? idx_q + 1'b1 : idx_q;
        cnt_d = accept ? '0 : (step && !last) ? cnt_q + 1'b1 : cnt_q;
        first_d = accept ? 1'b1 : step ? 1'b0 : first_q;
        done_d = step && last;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            mode_q <= MODE_CIRC;
            idx_q <= '0;
            cnt_q <= '0;
            first_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            first_q <= first_d;
            done_q <= done_d;
        end
    end

    assign idx_o = idx_q;
    assign step_valid_o = (state_q == ST_RUN);
    assign busy_o = (state_q == ST_RUN);
    assign first_o = first_q;
    assign last_o = last;
    assign step_cnt_o = cnt_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_cordic_iter_seq.sv
// tb_cordic_iter_seq: scoreboard bench; a list-based sequence model feeds a queue that a negedge monitor drains.
module tb_cordic_iter_seq;
    localparam int IDX_W = 5;
    localparam int MAX_IDX = 16;
    localparam int CNT_W = 6;

    typedef struct {
        int idx;
        int rep;
        int first;
        int last;
        int cnt;
    } exp_t;

    logic             clk = 0;
    logic             reset_i = 1;
    logic             start_i = 0;
    logic             mode_i = 0;
    logic             adv_i = 0;
    logic [IDX_W-1:0] idx_o;
    logic             step_valid_o, first_o, last_o, rep_o, busy_o, done_o;
    logic [CNT_W-1:0] step_cnt_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   expect_done = 0;

    cordic_iter_seq #(.IDX_W(IDX_W), .MAX_IDX(MAX_IDX), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .adv_i        (adv_i),
        .idx_o        (idx_o),
        .step_valid_o (step_valid_o),
        .first_o      (first_o),
        .last_o       (last_o),
        .rep_o        (rep_o),
        .step_cnt_o   (step_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Sequence as a list: every index once, repeat indices 4,13,40,... listed twice in hyperbolic mode.
    task automatic push_seq(input bit hyp);
        int   k = 4;
        int   ids[$];
        int   reps[$];
        exp_t e;
        for (int i = (hyp ? 1 : 0); i <= MAX_IDX; i++) begin
            ids.push_back(i);
            reps.push_back(0);
            if (hyp && i == k) begin
                ids.push_back(i);
                reps.push_back(1);
                k = 3 * k + 1;
            end
        end
        for (int n = 0; n < ids.size(); n++) begin
            e.idx = ids[n];
            e.rep = reps[n];
            e.first = (n == 0);
            e.last = (n == ids.size() - 1);
            e.cnt = n;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_i) begin
            if (expect_done || done_o) chk("done", int'(done_o), int'(expect_done));
            expect_done = 0;
            if (step_valid_o) begin
                if (sb.size() == 0) chk("unexpected_step", 1, 0);
                else begin
                    e = sb[0];
                    chk("idx", int'(idx_o), e.idx);
                    chk("rep", int'(rep_o), e.rep);
                    chk("first", int'(first_o), e.first);
                    chk("last", int'(last_o), e.last);
                    chk("step_cnt", int'(step_cnt_o), e.cnt);
                    chk("busy", int'(busy_o), 1);
                    if (adv_i) begin
                        void'(sb.pop_front());
                        if (e.last) expect_done = 1;
                    end
                end
            end
        end
    end

    task automatic start_seq(input bit hyp);
        for (int c = 0; c < 50 && busy_o; c++) begin
            @(posedge clk);
            #1;
        end
        start_i = 1;
        mode_i = hyp;
        push_seq(hyp);
        @(posedge clk);
        #1;
        start_i = 0;
    endtask

    task automatic run_until_done(input int advp, input bit junk);
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            adv_i = (advp >= 100) ? 1'b1 : ($urandom_range(0, 99) < advp);
            start_i = (junk && busy_o) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (junk) mode_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            seen = done_o;
        end
        start_i = 0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic adv_until_idx(input int target, input bit need_rep0);
        bit seen = 0;
        adv_i = 1;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (step_valid_o && int'(idx_o) == target && (!need_rep0 || !rep_o)) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) chk("idx_timeout", 0, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_idx"}, int'(idx_o), 0);
        chk({nm, "_cnt"}, int'(step_cnt_o), 0);
        chk({nm, "_outs"}, int'({step_valid_o, first_o, last_o, rep_o, busy_o, done_o}), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_i = 0;
        start_seq(1);
        run_until_done(100, 0);
        start_seq(0);
        run_until_done(100, 0);
        start_seq(1);
        adv_until_idx(4, 1);
        adv_i = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_idx", int'(idx_o), 4);
            chk("stall_rep", int'(rep_o), 0);
            chk("stall_cnt", int'(step_cnt_o), 3);
        end
        run_until_done(100, 0);
        start_seq(1);
        run_until_done(100, 1);
        start_seq(0);
        run_until_done(60, 1);
        start_seq(1);
        adv_until_idx(9, 0);
        reset_i = 1;
        sb.delete();
        expect_done = 0;
        @(posedge clk);
        #1;
        chk_zero("midrun_reset");
        reset_i = 0;
        start_seq(1);
        run_until_done(100, 0);
        start_i = 1;
        mode_i = 1;
        push_seq(1);
        @(posedge clk);
        #1;
        start_i = 0;
        chk("b2b_busy", int'(busy_o), 1);
        chk("b2b_first", int'(first_o), 1);
        chk("b2b_idx", int'(idx_o), 1);
        run_until_done(100, 0);
        for (int r = 0; r < 6; r++) begin
            start_seq(1'($urandom_range(0, 1)));
            run_until_done(50, 1);
        end
        @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
